// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: receive-side +1/-1 sequence checker for a counter stream
//   i_clk, i_rst (sync, active-high)  clock and reset
//   i_valid, i_mode, i_cnt            sample strobe, direction (1 = down), count sample
//   o_locked                          FSM is in LOCKED
//   o_err                             one-cycle pulse per mismatch while LOCKED
//   o_err_cnt                         saturating count of LOCKED mismatches
//   o_last                            last accepted sample
module cnt_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [WIDTH-1:0] o_last
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] exp_cnt;
  logic match;
  assign exp_cnt = i_mode ? prev_q - WIDTH'(1) : prev_q + WIDTH'(1);
  assign match = i_cnt == exp_cnt;
  // prev always follows the actual sample so the checker resyncs after any mismatch
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (i_valid) begin
      prev_d = i_cnt;
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          good_d  = '0;
        end
        SYNC: begin
          good_d = match ? good_q + GW'(1) : '0;
          if (match && good_d == GW'(LOCK_CNT)) begin
            state_d = LOCKED;
            bad_d   = '0;
          end
        end
        LOCKED: begin
          bad_d = match ? '0 : bad_q + BW'(1);
          if (!match) begin
            err_d     = 1'b1;
            err_cnt_d = err_cnt_q + ERR_W'(err_cnt_q != '1);
            if (bad_d == BW'(LOSS_CNT)) begin
              state_d = SYNC;
              good_d  = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign o_locked  = state_q == LOCKED;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
  assign o_last    = prev_q;
endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: directed bench for cnt_seq_checker
module tb_cnt_seq_checker;
  logic clk = 1'b0;
  logic rst, valid, mode;
  logic [7:0] cnt;
  logic locked, err;
  logic [15:0] err_cnt;
  logic [7:0] last;
  int n_run = 0;
  int n_fail = 0;
  cnt_seq_checker dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mode(mode), .i_cnt(cnt),
    .o_locked(locked), .o_err(err), .o_err_cnt(err_cnt), .o_last(last)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic v, input logic m, input logic [7:0] c);
    rst = r;
    valid = v;
    mode = m;
    cnt = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0);
  endtask
  initial begin
    rst = 1'b1;
    valid = 1'b0;
    mode = 1'b0;
    cnt = '0;
    do_reset();
    do_reset();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_last", 32'(last), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      chk($sformatf("t1_locked_%0d", i), 32'(locked), (i >= 4) ? 1 : 0);
      chk($sformatf("t1_err_%0d", i), 32'(err), 0);
    end
    chk("t1_err_cnt", 32'(err_cnt), 0);
    chk("t1_last", 32'(last), 9);
    do_reset();
    for (int i = 248; i <= 252; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    chk("t2_pre_locked", 32'(locked), 1);
    for (int i = 253; i <= 257; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      chk($sformatf("t2_err_%0d", i & 255), 32'(err), 0);
      chk($sformatf("t2_locked_%0d", i & 255), 32'(locked), 1);
    end
    chk("t2_last", 32'(last), 1);
    chk("t2_err_cnt", 32'(err_cnt), 0);
    do_reset();
    for (int i = 6; i <= 10; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    chk("t3_up_locked", 32'(locked), 1);
    for (int i = 9; i >= 7; i--) begin
      step(1'b0, 1'b1, 1'b1, 8'(i));
      chk($sformatf("t3_dn_err_%0d", i), 32'(err), 0);
    end
    chk("t3_dn_locked", 32'(locked), 1);
    chk("t3_dn_last", 32'(last), 7);
    do_reset();
    for (int i = 5; i >= 1; i--) step(1'b0, 1'b1, 1'b1, 8'(i));
    chk("t3_wrap_pre_locked", 32'(locked), 1);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    chk("t3_wrap_err0", 32'(err), 0);
    step(1'b0, 1'b1, 1'b1, 8'd255);
    chk("t3_wrap_err255", 32'(err), 0);
    chk("t3_wrap_last", 32'(last), 255);
    chk("t3_wrap_locked", 32'(locked), 1);
    chk("t3_wrap_err_cnt", 32'(err_cnt), 0);
    do_reset();
    for (int i = 16; i <= 20; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b1, 1'b0, 8'd50);
    chk("t4_err_pulse", 32'(err), 1);
    chk("t4_err_cnt", 32'(err_cnt), 1);
    chk("t4_locked_a", 32'(locked), 1);
    step(1'b0, 1'b1, 1'b0, 8'd51);
    chk("t4_err_clear", 32'(err), 0);
    chk("t4_locked_b", 32'(locked), 1);
    step(1'b0, 1'b1, 1'b0, 8'd52);
    chk("t4_err_52", 32'(err), 0);
    chk("t4_err_cnt_end", 32'(err_cnt), 1);
    chk("t4_last", 32'(last), 52);
    do_reset();
    for (int i = 16; i <= 20; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(20 * (k + 1)));
      chk($sformatf("t5_err_%0d", k), 32'(err), 1);
      chk($sformatf("t5_err_cnt_%0d", k), 32'(err_cnt), 32'(k));
      chk($sformatf("t5_locked_%0d", k), 32'(locked), (k < 3) ? 1 : 0);
    end
    for (int i = 81; i <= 84; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      chk($sformatf("t5_relock_%0d", i), 32'(locked), (i == 84) ? 1 : 0);
      chk($sformatf("t5_relock_err_%0d", i), 32'(err), 0);
    end
    chk("t5_err_cnt_end", 32'(err_cnt), 3);
    step(1'b0, 1'b1, 1'b0, 8'd90);
    chk("t6_err_pre_gap", 32'(err), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd200);
      chk($sformatf("t6_gap_err_%0d", i), 32'(err), 0);
      chk($sformatf("t6_gap_locked_%0d", i), 32'(locked), 1);
      chk($sformatf("t6_gap_err_cnt_%0d", i), 32'(err_cnt), 4);
      chk($sformatf("t6_gap_last_%0d", i), 32'(last), 90);
    end
    step(1'b1, 1'b1, 1'b0, 8'd99);
    chk("t6_rst_locked", 32'(locked), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_err_cnt", 32'(err_cnt), 0);
    chk("t6_rst_last", 32'(last), 0);
    for (int i = 0; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      chk($sformatf("t6_relock_%0d", i), 32'(locked), (i == 4) ? 1 : 0);
    end
    chk("t6_err_cnt_end", 32'(err_cnt), 0);
    chk("t6_last_end", 32'(last), 4);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
